// File: rtl/prbs_bist_ctrl.sv
// prbs_bist_ctrl: BIST sequencer that seeds and runs the PRBS generator, locks onto the loopback and counts errors.
// Define PRBS_BIT_ERR_CNT_EN to make err_cnt accumulate bit errors instead of word errors.
module prbs_bist_ctrl #(
   parameter int WIDTH     = 24,
   parameter int TAP1      = 6,
   parameter int TAP2      = 5,
   parameter int CNT_W     = 16,
   parameter int ERR_W     = 16,
   parameter int LOCK_CNT  = 4,
   parameter int DRAIN_CYC = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] num_words,
   input  logic [WIDTH-1:0] seed,
   output logic             gen_load,
   output logic [WIDTH-1:0] gen_seed,
   output logic             gen_en,
   input  logic [WIDTH-1:0] rx_data,
   input  logic             rx_valid,
   output logic             busy,
   output logic             locked,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [CNT_W-1:0] word_cnt
);
   localparam int IW = $clog2(DRAIN_CYC + 1);
   localparam int MW = $clog2(LOCK_CNT + 1);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

   state_t           state, nxt;
   logic [CNT_W-1:0] tx_cnt;
   logic [IW-1:0]    idle_cnt;
   logic [MW-1:0]    match_cnt;
   logic [WIDTH-1:0] expected;
   logic [ERR_W-1:0] err_nxt;
   logic             seen, active, hit, drain_end;

   function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] y;
      y = x;
      for (int i = 0; i < WIDTH; i++) y = {y[WIDTH-2:0], y[TAP1] ^ y[TAP2]};
      return y;
   endfunction

   assign active    = (state == RUN || state == DRAIN) && rx_valid;
   assign hit       = rx_data == expected;
   assign drain_end = !rx_valid && idle_cnt == IW'(DRAIN_CYC - 1);

`ifdef PRBS_BIT_ERR_CNT_EN
   logic [ERR_W:0] err_sum;
   always_comb begin
      err_sum = {1'b0, err_cnt};
      for (int i = 0; i < WIDTH; i++) err_sum = err_sum + (ERR_W+1)'(rx_data[i] ^ expected[i]);
   end
   assign err_nxt = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
`else
   assign err_nxt = (err_cnt == '1) ? err_cnt : err_cnt + ERR_W'(1);
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = (start && !stop) ? LOAD : IDLE;
         LOAD:    nxt = stop ? DONE : (num_words == '0) ? DRAIN : RUN;
         RUN:     nxt = stop ? DONE : (tx_cnt + CNT_W'(1) == num_words) ? DRAIN : RUN;
         DRAIN:   nxt = (stop || drain_end) ? DONE : DRAIN;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      gen_load = state == LOAD;
      gen_seed = (state == LOAD) ? seed : '0;
      gen_en   = state == RUN;
      busy     = state != IDLE;
      done     = state == DONE;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_cnt    <= '0;
         idle_cnt  <= '0;
         match_cnt <= '0;
         expected  <= '0;
         seen      <= 1'b0;
         locked    <= 1'b0;
         pass      <= 1'b0;
         err_cnt   <= '0;
         word_cnt  <= '0;
      end else begin
         tx_cnt   <= (state == RUN) ? tx_cnt + CNT_W'(1) : '0;
         idle_cnt <= (state == DRAIN && !rx_valid) ? idle_cnt + IW'(1) : '0;
         if (state == IDLE && nxt == LOAD) begin
            err_cnt  <= '0;
            word_cnt <= '0;
            locked   <= 1'b0;
            pass     <= 1'b0;
         end
         // Result is latched on entry to DONE; an abort always reports fail.
         if (state != DONE && nxt == DONE)
            pass <= state == DRAIN && !stop && locked && err_cnt == '0 && word_cnt != '0;
         if (state == LOAD) begin
            seen      <= 1'b0;
            match_cnt <= '0;
            expected  <= '0;
            locked    <= 1'b0;
         end else if (active) begin
            if (locked) begin
               expected <= step(expected);
               if (word_cnt != '1) word_cnt <= word_cnt + CNT_W'(1);
               if (!hit) err_cnt <= err_nxt;
            end else if (seen && hit) begin
               expected  <= step(expected);
               match_cnt <= match_cnt + MW'(1);
               if (match_cnt == MW'(LOCK_CNT - 1)) locked <= 1'b1;
            end else begin
               expected  <= step(rx_data);
               match_cnt <= '0;
               seen      <= 1'b1;
            end
         end
      end
   end
endmodule
